windowed_fir_mac: RTL
=====================

// Module: windowed_fir_mac
// PURPOSE
//  Parametrised windowed FIR: stores the last TAPS signed samples in a circular buffer.
//  On each input strobe it runs one multiply-accumulate per clock against an external
//  window-coefficient ROM (Hann or other), then emits a scaled result with a valid pulse.
//  Sits between the audio sample decimator and the spectral/energy stages. Adds fill
//  tracking, overrun reporting, output scaling and a busy flag.
// PARAMETERS
//  SAMPLE_W   8    signed sample width
//  COEFF_W    10   signed coefficient width
//  TAPS       400  window length / buffer depth (>=2)
//  OUT_W      28   output width
//  OUT_SHIFT  0    arithmetic right shift applied to accumulator before output
//  (local) AW = clog2(TAPS); ACC_W = SAMPLE_W+COEFF_W+clog2(TAPS)
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-high reset
//  ready       in   1        one-cycle strobe: x is a new sample
//  x           in   SAMPLE_W signed sample, valid when ready=1
//  coeff_addr  out  AW       tap index to ROM (combinational ROM, same-cycle data)
//  coeff_data  in   COEFF_W  signed coefficient for coeff_addr
//  y           out  OUT_W    signed filtered result
//  y_valid     out  1        one-cycle pulse: y updated
//  busy        out  1        high in MAC or DONE
//  overrun     out  1        one-cycle pulse: ready arrived while busy
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, fill=0, idx=0, acc=0, y=0, y_valid=0, overrun=0.
//   Buffer RAM is not cleared; fill masks stale entries.
//  States: IDLE -> MAC -> DONE -> IDLE.
//  ready (any state): buf[wr_ptr]<=x; newest<=wr_ptr; wr_ptr<=wr_ptr+1 (wraps TAPS-1->0);
//   fill<=min(fill+1,TAPS); acc<=0; idx<=0; state<=MAC. ready has priority over all else.
//   If state was MAC or DONE: overrun=1 next cycle; aborted result is discarded (no y_valid).
//  MAC: coeff_addr=idx; acc<=acc+coeff_data*tap, where tap=buf[(newest-idx) mod TAPS]
//   if idx<fill, else 0. idx<=idx+1. After idx==TAPS-1 is accumulated, state<=DONE.
//  DONE: y<=scaled(acc); y_valid<=1 (visible the following cycle); state<=IDLE.
//  Latency: ready at edge E0 -> MAC at E1..E_TAPS -> y/y_valid high after edge E_TAPS+1.
//  Full products sign-extended to ACC_W; no intermediate truncation.
//  scaled(a) = (a >>> OUT_SHIFT), low OUT_W bits kept (no saturation).
//  coeff_addr=0 in IDLE/DONE. busy = (state!=IDLE).
//  Reset mid-MAC: abort immediately, no y_valid, fill=0 (history forgotten).
// CONFIGURATION
//  WINFIR_ROUND_EN defined: if OUT_SHIFT>0, scaled(a) = (a + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT
//   (round half up); accumulator is extended by 1 bit for the add.
//  Undefined: plain arithmetic shift (truncate toward -inf). OUT_SHIFT=0: identical either way.
// TESTING (TAPS=4, bench ROM coeff={1,2,3,4} unless noted)
//  Impulse: reset; ready x=1, then ready x=0 x3 spaced >=6 cycles -> y=1,2,3,4,
//   one y_valid each, exactly 5 cycles after each ready.
//  Step/wrap: 9 strobes of x=10 -> y=10,30,60,100,100,100,100,100,100.
//   fill masking on first 3; wr_ptr wraps twice.
//  Extremes: coeff all -512, 4 strobes x=-128 -> final y=262144, no overflow.
//  Overrun: ready x=5, then ready x=7 two cycles later -> overrun pulse 1 cycle.
//   Single y_valid 5 cycles after 2nd ready, y=7*1+5*2=17.
//  Reset mid-MAC: ready x=9, reset at MAC cycle 2 -> y=0, no y_valid, busy=0.
//   Next ready x=1 -> y=1.
//  Rounding (OUT_SHIFT=2, coeff={6,0,0,0}): x=1 -> y=1 without WINFIR_ROUND_EN, 2 with.
//   x=-1 -> y=-2 without, -1 with.

Source files
------------

// File: rtl/windowed_fir_mac.sv
// Windowed FIR: TAPS-deep circular sample history, one multiply-accumulate per clock against an
// external combinational coefficient ROM. Optional macro WINFIR_ROUND_EN selects round-half-up output scaling.
module windowed_fir_mac #(
    parameter int SAMPLE_W  = 8,
    parameter int COEFF_W   = 10,
    parameter int TAPS      = 400,
    parameter int OUT_W     = 28,
    parameter int OUT_SHIFT = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ready,
    input  logic signed [SAMPLE_W-1:0]  x,
    output logic [$clog2(TAPS)-1:0]     coeff_addr,
    input  logic signed [COEFF_W-1:0]   coeff_data,
    output logic signed [OUT_W-1:0]     y,
    output logic                        y_valid,
    output logic                        busy,
    output logic                        overrun
);
    localparam int AW    = $clog2(TAPS);
    localparam int FW    = $clog2(TAPS + 1);
    localparam int PW    = SAMPLE_W + COEFF_W;
    localparam int ACC_W = PW + AW;
    localparam int EXT_W = (OUT_W > ACC_W + 1) ? OUT_W : ACC_W + 1;
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

`ifdef WINFIR_ROUND_EN
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] RND = (OUT_SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
`else
    localparam logic signed [EXT_W-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t state_reg, state_next;

    logic signed [SAMPLE_W-1:0] buf_mem [TAPS];
    logic [AW-1:0]              wr_ptr_reg, newest_reg, idx_reg, rd_addr;
    logic [FW-1:0]              fill_reg;
    logic signed [ACC_W-1:0]    acc_reg, prod_ext;
    logic signed [SAMPLE_W-1:0] tap;
    logic signed [PW-1:0]       prod;
    logic signed [EXT_W-1:0]    acc_ext, rounded, shifted;

    // Newest sample minus idx, modulo TAPS, without a wider intermediate.
    assign rd_addr  = (newest_reg >= idx_reg) ? newest_reg - idx_reg
                                              : newest_reg + (LAST - idx_reg) + AW'(1);
    assign tap      = (FW'(idx_reg) < fill_reg) ? buf_mem[rd_addr] : '0;
    assign prod     = PW'(coeff_data) * PW'(tap);
    assign prod_ext = ACC_W'(prod);

    assign acc_ext  = EXT_W'(acc_reg);
    assign rounded  = acc_ext + RND;
    assign shifted  = rounded >>> OUT_SHIFT;

    assign busy       = (state_reg != IDLE);
    assign coeff_addr = (state_reg == MAC) ? idx_reg : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = IDLE;
            MAC:     if (idx_reg == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (ready) state_next = MAC;
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // History is never cleared; fill_reg hides entries written before the last reset.
    always_ff @(posedge clk) begin
        if (ready) buf_mem[wr_ptr_reg] <= x;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            newest_reg <= '0;
            fill_reg   <= '0;
            idx_reg    <= '0;
            acc_reg    <= '0;
            y          <= '0;
            y_valid    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            overrun <= ready && (state_reg != IDLE);
            if (ready) begin
                newest_reg <= wr_ptr_reg;
                wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + AW'(1);
                if (fill_reg != FW'(TAPS)) fill_reg <= fill_reg + FW'(1);
                acc_reg <= '0;
                idx_reg <= '0;
            end else if (state_reg == MAC) begin
                acc_reg <= acc_reg + prod_ext;
                idx_reg <= (idx_reg == LAST) ? '0 : idx_reg + AW'(1);
            end else if (state_reg == DONE) begin
                y       <= OUT_W'(shifted);
                y_valid <= 1'b1;
            end
        end
    end
endmodule
